// File: rtl/rv32i_pkg.sv
// Shared encodings for the rv32i multicycle datapath: ALU ops, opcodes,
// control-FSM states and the datapath mux select codes.
package rv32i_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_R     = 2'd1,
    CLS_I     = 2'd2
  } op_class_t;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_alu_decoder.sv
// Combinational ALU decoder: maps instruction class and funct fields to an
// ALU operation, flagging funct combinations the core does not implement.
module alu_decoder
  import rv32i_pkg::*;
(
  input  op_class_t   i_class,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7_5,
  output logic [3:0]  o_alu_op,
  output logic        o_illegal
);

  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_class)
      CLS_R: begin
        case (i_funct3)
          3'b000:  o_alu_op = i_funct7_5 ? ALU_SUB : ALU_ADD;
          3'b110:  o_alu_op = ALU_OR;
          3'b111:  o_alu_op = ALU_AND;
          default: o_illegal = 1'b1;
        endcase
      end
      CLS_I: begin
        // funct7_5 is an immediate bit here, so it never selects SUB
        case (i_funct3)
          3'b000:  o_alu_op = ALU_ADD;
          3'b110:  o_alu_op = ALU_OR;
          3'b111:  o_alu_op = ALU_AND;
          default: o_illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle rv32i control FSM: sequences fetch/decode/execute/memory/writeback
// and stalls on MemReady in the memory-access states.
module mc_control
  import rv32i_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       ZERO,
  input  logic       MemReady,
  output logic [3:0] ALU_Operation,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       Illegal,
  output logic       Retire
);

  state_t     r_state;
  state_t     w_state_next;
  op_class_t  w_class;
  logic [3:0] w_alu_op;
  logic       w_funct_illegal;

  assign w_class = (opcode == OP_RTYPE) ? CLS_R :
                   (opcode == OP_ITYPE) ? CLS_I : CLS_OTHER;

  alu_decoder u_alu_decoder (
    .i_class    (w_class),
    .i_funct3   (funct3),
    .i_funct7_5 (funct7_5),
    .o_alu_op   (w_alu_op),
    .o_illegal  (w_funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    ALU_Operation = ALU_ADD;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RD2;
    ResultSrc     = RES_ALUOUT;
    ImmSrc        = imm_src(opcode);
    AdrSrc        = ADR_PC;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegWrite      = 1'b0;
    Illegal       = 1'b0;
    Retire        = 1'b0;
    // Reset forces every select to zero, so an abandoned instruction issues no write
    if (rst) begin
      ImmSrc       = IMM_I;
      w_state_next = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          MemRead   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          if (MemReady) begin
            IRWrite      = 1'b1;
            PCWrite      = 1'b1;
            w_state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          case (opcode)
            OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
            OP_RTYPE: begin
              w_state_next = w_funct_illegal ? S_FETCH : S_EXECR;
              Illegal      = w_funct_illegal;
            end
            OP_ITYPE: begin
              w_state_next = w_funct_illegal ? S_FETCH : S_EXECI;
              Illegal      = w_funct_illegal;
            end
            OP_BRANCH: begin
              w_state_next = (funct3 == 3'b000) ? S_BEQ : S_FETCH;
              Illegal      = (funct3 != 3'b000);
            end
            OP_JAL: w_state_next = S_JAL;
            default: begin
              w_state_next = S_FETCH;
              Illegal      = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA      = SRCA_RD1;
          ALUSrcB      = SRCB_IMM;
          w_state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          AdrSrc  = ADR_RESULT;
          MemRead = 1'b1;
          if (MemReady) w_state_next = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc    = RES_DATA;
          RegWrite     = 1'b1;
          Retire       = 1'b1;
          w_state_next = S_FETCH;
        end
        S_MEMWRITE: begin
          AdrSrc   = ADR_RESULT;
          MemWrite = 1'b1;
          if (MemReady) begin
            Retire       = 1'b1;
            w_state_next = S_FETCH;
          end
        end
        S_EXECR: begin
          ALUSrcA       = SRCA_RD1;
          ALU_Operation = w_alu_op;
          w_state_next  = S_ALUWB;
        end
        S_EXECI: begin
          ALUSrcA       = SRCA_RD1;
          ALUSrcB       = SRCB_IMM;
          ALU_Operation = w_alu_op;
          w_state_next  = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite     = 1'b1;
          Retire       = 1'b1;
          w_state_next = S_FETCH;
        end
        S_BEQ: begin
          ALUSrcA       = SRCA_RD1;
          ALU_Operation = ALU_SUB;
          PCWrite       = ZERO;
          Retire        = 1'b1;
          w_state_next  = S_FETCH;
        end
        S_JAL: begin
          ALUSrcA      = SRCA_OLDPC;
          ALUSrcB      = SRCB_FOUR;
          PCWrite      = 1'b1;
          w_state_next = S_ALUWB;
        end
        default: w_state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Randomized scoreboard bench for mc_control: an instruction-level model
// expands each instruction into its expected per-cycle control words.
module tb_mc_control;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [1:0] imm;
    logic       adr;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       pcw;
    logic       rgw;
    logic       ill;
    logic       ret;
  } ctl_t;

  typedef struct {
    logic rst;
    logic mr;
    ctl_t exp;
    int   tag;
  } cyc_t;

  typedef struct {
    ctl_t exp;
    int   tag;
  } sb_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;
  localparam int P_RST = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMREAD = 4,
                 P_MEMWB = 5, P_MEMWRITE = 6, P_EXECR = 7, P_EXECI = 8, P_ALUWB = 9,
                 P_BEQ = 10, P_JAL = 11;
  string ph_name [12] = '{"reset", "fetch", "decode", "memadr", "memread", "memwb",
                          "memwrite", "execr", "execi", "aluwb", "beq", "jal"};
  string kind_name [7] = '{"lw", "sw", "R", "I", "beq", "jal", "illegal"};

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       ZERO;
  logic       MemReady;
  logic [3:0] ALU_Operation;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic       AdrSrc, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, Illegal, Retire;

  int checks = 0;
  int errors = 0;
  int n_instr = 0;
  sb_t sb_q[$];

  mc_control dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .ZERO          (ZERO),
    .MemReady      (MemReady),
    .ALU_Operation (ALU_Operation),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ResultSrc     (ResultSrc),
    .ImmSrc        (ImmSrc),
    .AdrSrc        (AdrSrc),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .RegWrite      (RegWrite),
    .Illegal       (Illegal),
    .Retire        (Retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level classification straight from the ISA subset rules
  function automatic void classify(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                   output int kind, output logic [3:0] aop);
    kind = K_ILL;
    aop  = 4'b0010;
    if (op == 7'b0000011) kind = K_LW;
    else if (op == 7'b0100011) kind = K_SW;
    else if (op == 7'b1101111) kind = K_JAL;
    else if (op == 7'b1100011 && f3 == 3'b000) kind = K_BEQ;
    else if (op == 7'b0110011 || op == 7'b0010011) begin
      if (f3 == 3'b000) begin
        kind = (op == 7'b0110011) ? K_R : K_I;
        aop  = (op == 7'b0110011 && f75) ? 4'b0110 : 4'b0010;
      end else if (f3 == 3'b110) begin
        kind = (op == 7'b0110011) ? K_R : K_I;
        aop  = 4'b0001;
      end else if (f3 == 3'b111) begin
        kind = (op == 7'b0110011) ? K_R : K_I;
        aop  = 4'b0000;
      end
    end
  endfunction

  function automatic cyc_t cyc(input logic r, input logic mr, input ctl_t e, input int tag);
    cyc_t c;
    c.rst = r;
    c.mr  = mr;
    c.exp = e;
    c.tag = tag;
    return c;
  endfunction

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input int fst, input int mst, input logic z, input int abort_at);
    cyc_t seq[$];
    int kind;
    logic [3:0] aop;
    ctl_t base, e;
    classify(op, f3, f75, kind, aop);
    base = '0;
    base.alu = 4'b0010;
    base.imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
               (op == 7'b1101111) ? 2'b11 : 2'b00;
    e = base; e.mrd = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
    for (int i = 0; i < fst; i++) seq.push_back(cyc(1'b0, 1'b0, e, P_FETCH));
    e.irw = 1'b1; e.pcw = 1'b1;
    seq.push_back(cyc(1'b0, 1'b1, e, P_FETCH));
    e = base; e.srca = 2'b01; e.srcb = 2'b01; e.ill = (kind == K_ILL);
    seq.push_back(cyc(1'b0, 1'($urandom_range(0, 1)), e, P_DECODE));
    if (kind == K_LW || kind == K_SW) begin
      e = base; e.srca = 2'b10; e.srcb = 2'b01;
      seq.push_back(cyc(1'b0, 1'($urandom_range(0, 1)), e, P_MEMADR));
      e = base; e.adr = 1'b1;
      if (kind == K_LW) e.mrd = 1'b1; else e.mwr = 1'b1;
      for (int i = 0; i < mst; i++)
        seq.push_back(cyc(1'b0, 1'b0, e, (kind == K_LW) ? P_MEMREAD : P_MEMWRITE));
      if (kind == K_SW) e.ret = 1'b1;
      seq.push_back(cyc(1'b0, 1'b1, e, (kind == K_LW) ? P_MEMREAD : P_MEMWRITE));
      if (kind == K_LW) begin
        e = base; e.res = 2'b01; e.rgw = 1'b1; e.ret = 1'b1;
        seq.push_back(cyc(1'b0, 1'($urandom_range(0, 1)), e, P_MEMWB));
      end
    end else if (kind == K_R || kind == K_I || kind == K_JAL) begin
      e = base;
      if (kind == K_JAL) begin
        e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1;
      end else begin
        e.srca = 2'b10; e.srcb = (kind == K_I) ? 2'b01 : 2'b00; e.alu = aop;
      end
      seq.push_back(cyc(1'b0, 1'($urandom_range(0, 1)), e,
                        (kind == K_JAL) ? P_JAL : (kind == K_I) ? P_EXECI : P_EXECR));
      e = base; e.rgw = 1'b1; e.ret = 1'b1;
      seq.push_back(cyc(1'b0, 1'($urandom_range(0, 1)), e, P_ALUWB));
    end else if (kind == K_BEQ) begin
      e = base; e.srca = 2'b10; e.alu = 4'b0110; e.pcw = z; e.ret = 1'b1;
      seq.push_back(cyc(1'b0, 1'($urandom_range(0, 1)), e, P_BEQ));
    end
    if (abort_at >= 0 && abort_at < seq.size()) begin
      while (seq.size() > abort_at) void'(seq.pop_back());
      e = '0; e.alu = 4'b0010;
      seq.push_back(cyc(1'b1, 1'($urandom_range(0, 1)), e, P_RST));
    end
    $display("instr %0d op=%b f3=%b f7_5=%b zero=%b kind=%s cycles=%0d%s", n_instr, op, f3, f75,
             z, kind_name[kind], seq.size(), (abort_at >= 0 && seq[seq.size()-1].rst) ? " (reset abort)" : "");
    n_instr++;
    foreach (seq[i]) begin
      @(posedge clk);
      #1;
      rst      = seq[i].rst;
      opcode   = op;
      funct3   = f3;
      funct7_5 = f75;
      ZERO     = z;
      MemReady = seq[i].mr;
      sb_q.push_back('{exp: seq[i].exp, tag: seq[i].tag});
    end
  endtask

  // Monitor: compares the DUT's control word against the scoreboard every cycle
  initial begin
    sb_t s;
    ctl_t act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        s = sb_q.pop_front();
        act = '{ALU_Operation, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc, MemRead, MemWrite,
                IRWrite, PCWrite, RegWrite, Illegal, Retire};
        checks++;
        if (act !== s.exp) begin
          errors++;
          $display("FAIL %s @%0t: got %b want %b (alu|srca|srcb|res|imm|adr mrd mwr irw pcw rgw ill ret)",
                   ph_name[s.tag], $time, act, s.exp);
        end
      end
    end
  end

  initial begin
    int kind_sel, wait_cyc;
    logic [6:0] op;
    logic [2:0] f3;
    rst = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; ZERO = 1'b0; MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ctl_t e;
      @(posedge clk);
      #1;
      MemReady = 1'($urandom_range(0, 1));
      e = '0; e.alu = 4'b0010;
      sb_q.push_back('{exp: e, tag: P_RST});
    end

    run_instr(7'b0000011, 3'b010, 1'b0, 0, 0, 1'b0, -1);  // lw, no stalls
    run_instr(7'b0100011, 3'b010, 1'b0, 0, 3, 1'b0, -1);  // sw, 3 stall cycles
    run_instr(7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0, -1);  // sub
    run_instr(7'b0110011, 3'b111, 1'b0, 0, 0, 1'b0, -1);  // and
    run_instr(7'b0110011, 3'b110, 1'b0, 0, 0, 1'b0, -1);  // or
    run_instr(7'b0010011, 3'b000, 1'b1, 1, 0, 1'b0, -1);  // addi with imm bit set
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1, -1);  // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0, -1);  // beq not taken
    run_instr(7'b1101111, 3'b000, 1'b0, 2, 0, 1'b0, -1);  // jal, fetch stall
    run_instr(7'b0110111, 3'b000, 1'b0, 0, 0, 1'b0, -1);  // lui is illegal
    run_instr(7'b0110011, 3'b001, 1'b0, 0, 0, 1'b0, -1);  // R funct3=001 is illegal
    run_instr(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b1, -1);  // bne is illegal
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, 1'b0, 4);   // reset during memread stall
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 0, 1'b0, -1);  // restarts cleanly from fetch

    for (int n = 0; n < 60; n++) begin
      kind_sel = $urandom_range(0, 7);
      f3 = 3'($urandom_range(0, 7));
      case (kind_sel)
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4: begin op = 7'b1100011; if ($urandom_range(0, 3) != 0) f3 = 3'b000; end
        5: op = 7'b1101111;
        6: op = 7'($urandom_range(0, 127));
        default: op = 7'b0110111;
      endcase
      run_instr(op, f3, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1);
    end

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle control FSM for the rv32i multicycle datapath.
- Producer side of the ALU interface: generates ALU_Operation (AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110) plus operand-select, memory and write-enable strobes.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and stalls on a memory-ready handshake.

Parameters:
- None. All encodings are fixed constants in the shared package.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- opcode  in  7  instruction register [6:0]
- funct3  in  3  instruction register [14:12]
- funct7_5  in  1  instruction register [30]
- ZERO  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- ALU_Operation  out  4  ALU operation code
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 DataReg, 10 ALU_result direct
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; combinational from opcode
- AdrSrc  out  1  0 PC, 1 Result
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- PCWrite  out  1  PC load
- RegWrite  out  1  register file write
- Illegal  out  1  one-cycle pulse on an unsupported instruction
- Retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- State register updates on the clk rising edge. Outputs decode from state (Moore), except PCWrite, IRWrite and the FETCH exit, which also depend on MemReady/ZERO.
- While rst=1:
  - All strobes are 0: MemRead, MemWrite, IRWrite, PCWrite, RegWrite, Illegal, Retire.
  - Selects are 0; ALU_Operation=ADD.
  - State loads FETCH at the edge.
- Reset mid-instruction abandons the instruction with no write issued.
- States and transitions:
  - FETCH: AdrSrc=0, MemRead=1, A=00, B=10, ADD, ResultSrc=10. If MemReady: IRWrite=1, PCWrite=1, go to DECODE; else hold with IRWrite/PCWrite=0.
  - DECODE: A=01, B=01, ADD (branch/jump target into ALUOut). Next state:
    - lw (0000011) or sw (0100011) -> MEMADR
    - R (0110011) -> EXECR
    - I-ALU (0010011) -> EXECI
    - beq (1100011, funct3=000) -> BEQ
    - jal (1101111) -> JAL
    - anything else, including unsupported funct3/funct7_5 combinations -> FETCH with Illegal=1 for this cycle
  - MEMADR: A=10, B=01, ADD -> MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: AdrSrc=1, ResultSrc=00, MemRead=1. Hold until MemReady, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, Retire=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Hold until MemReady; in the MemReady cycle Retire=1 and go to FETCH.
  - EXECR: A=10, B=00, op from funct -> ALUWB.
  - EXECI: A=10, B=01, op from funct3 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, Retire=1 -> FETCH.
  - BEQ: A=10, B=00, SUB, ResultSrc=00, PCWrite=ZERO, Retire=1 -> FETCH.
  - JAL: A=01, B=10, ADD, ResultSrc=00, PCWrite=1 -> ALUWB (writes PC+4 to rd).
- ALU decode:
  - R-type: funct3 000 with f7_5=0 -> ADD; 000 with f7_5=1 -> SUB; 110 -> OR; 111 -> AND.
  - I-type: 000 -> ADD; 110 -> OR; 111 -> AND.
  - All other combinations are illegal.
- Latencies with MemReady always 1: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4.
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- MemRead/MemWrite stay asserted and stable through a stall. MemReady is ignored in all other states.
- MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.

Decomposition:
- Shared package rv32i_pkg:
  - ALU op localparams AND/OR/ADD/SUB
  - opcode constants
  - 4-bit state encodings
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings
- One combinational sub-module, alu_decoder: (opcode class, funct3, funct7_5) -> ALU_Operation plus an illegal flag. mc_control instantiates it.

Test Plan:
- Reset, then release with MemReady=1 and lw opcode:
  - States FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - RegWrite=1 and ResultSrc=01 only in cycle 5.
  - Retire pulses once.
- sw with MemReady low for 3 cycles in MEMWRITE:
  - MemWrite held 4 cycles, AdrSrc=1.
  - Retire only in the MemReady cycle.
  - RegWrite never asserts.
- R-type funct3=000, f7_5=1 -> ALU_Operation=0110 in EXECR. funct3=111 -> 0000. funct3=110 -> 0001. Each followed by an ALUWB RegWrite.
- beq with ZERO=1 -> PCWrite=1 in the BEQ cycle. With ZERO=0 -> PCWrite=0. Both return to FETCH after 3 cycles.
- Opcode 0110111 (lui) or R funct3=001 -> Illegal pulses 1 cycle in DECODE, next state FETCH, no RegWrite/MemWrite.
- rst asserted during MEMREAD stall -> all strobes 0 that cycle; next cycle FETCH with MemRead=1 and AdrSrc=0.
